button_conditioner: RTL and testbench

//  Front-end for the clock's push-buttons (mode, sel, inc, stop_alarm): 2-FF sync, debounce,

---
 rtl/clock_pkg.sv | 14 +
 rtl/button_conditioner_if.sv | 14 +
 rtl/btn_debounce_1b.sv | 102 ++++++++++
 rtl/button_conditioner.sv | 41 ++++
 tb/tb_button_conditioner.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock front-end: button bit positions and the
// per-button auto-repeat state encoding.
package clock_pkg;
  localparam int BTN_MODE = 0;
  localparam int BTN_SEL  = 1;
  localparam int BTN_INC  = 2;
  localparam int BTN_STOP = 3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;
endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the clock logic.
// master = pin side / consumer, slave = conditioner.
interface button_conditioner_if #(parameter int NUM_BTN = 4);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_hold;

  modport master (output btn_raw,
                  input  btn_level, btn_press, btn_release, btn_hold);
  modport slave  (input  btn_raw,
                  output btn_level, btn_press, btn_release, btn_hold);
endinterface

// File: rtl/btn_debounce_1b.sv
// One button: 2-FF sync, debounce, press/release pulses and auto-repeat FSM.
module btn_debounce_1b
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic rpt_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic          REL_LVL = ACTIVE_LOW_IN;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          level_q, level_d, press_q, press_d, rel_q, rel_d, hold_q, hold_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  rpt_state_e    state_q, state_d;
  logic          s, rise, fall, rpt_pulse;

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    s         = sync2_q ^ REL_LVL;
    level_d   = level_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rpt_pulse = 1'b0;

    if (s == level_q)          cnt_d = '0;
    else if (cnt_q == DB_LAST) begin level_d = s; cnt_d = '0; end
    else                       cnt_d = cnt_q + 1'b1;

    rise = level_d & ~level_q;
    fall = ~level_d & level_q;

    // An accepted release overrides any repeat terminal count on the same edge.
    if (fall) begin
      state_d = RPT_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        RPT_IDLE: if (rise && rpt_en) begin state_d = RPT_WAIT; rcnt_d = '0; end
        RPT_WAIT:
          if (rcnt_q == RD_LAST) begin
            state_d = RPT_REPEAT; rcnt_d = '0; rpt_pulse = 1'b1;
          end else rcnt_d = rcnt_q + 1'b1;
        RPT_REPEAT:
          if (rcnt_q == RP_LAST) begin rcnt_d = '0; rpt_pulse = 1'b1; end
          else rcnt_d = rcnt_q + 1'b1;
        default: state_d = RPT_IDLE;
      endcase
    end

    press_d = rise | rpt_pulse;
    rel_d   = fall;
    hold_d  = (state_d == RPT_REPEAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      state_q <= RPT_IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign hold  = hold_q;
endmodule

// File: rtl/button_conditioner.sv
// Push-button front-end: one independent conditioner per button.
// Default auto-repeat only on the inc button.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 20,
  parameter int                 REPEAT_DELAY    = 500,
  parameter int                 REPEAT_PERIOD   = 100,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(1) << BTN_INC,
  parameter bit                 ACTIVE_LOW_IN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);
  logic [NUM_BTN-1:0] lvl, prs, rls, hld;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce_1b #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .ACTIVE_LOW_IN   (ACTIVE_LOW_IN)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (bus.btn_raw[i]),
      .rpt_en (REPEAT_MASK[i]),
      .level  (lvl[i]),
      .press  (prs[i]),
      .rel    (rls[i]),
      .hold   (hld[i])
    );
  end

  assign bus.btn_level   = lvl;
  assign bus.btn_press   = prs;
  assign bus.btn_release = rls;
  assign bus.btn_hold    = hld;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: expected press/release events are queued as stimulus is
// driven and matched by a monitor whenever the DUT emits a pulse.
module tb_button_conditioner;
  import clock_pkg::*;

  logic clk, rst;
  int   cyc = 0;
  int   total = 0, bad = 0;

  typedef struct { int cyc; int b; bit rel; } ev_t;
  ev_t exp_q[$];

  button_conditioner_if #(.NUM_BTN(4)) bif ();

  button_conditioner #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
    .REPEAT_MASK(4'b0100), .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push_ev(input int t, input int b, input bit r);
    ev_t e;
    e.cyc = t; e.b = b; e.rel = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Event key: cycle, bit and kind (1 = press, 2 = release).
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bif.btn_press[b] || bif.btn_release[b]) begin
        chk("spurious_pulse", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event", cyc*64 + b*4 + {bif.btn_release[b], bif.btn_press[b]},
              e.cyc*64 + e.b*4 + (e.rel ? 2 : 1));
        end
      end
    end
  end

  initial begin
    int c, p, q;
    clk = 1'b0;
    rst = 1'b1;
    bif.btn_raw = 4'b0000;

    // Reset with all buttons held down
    repeat (3) @(negedge clk);
    chk("rst_level",   int'(bif.btn_level),   0);
    chk("rst_press",   int'(bif.btn_press),   0);
    chk("rst_release", int'(bif.btn_release), 0);
    chk("rst_hold",    int'(bif.btn_hold),    0);
    c = cyc;
    rst = 1'b0;
    for (int b = 0; b < 4; b++) push_ev(c + 6, b, 1'b0);
    wait_cyc(c + 5); chk("rst_lvl_early", int'(bif.btn_level), 0);
    wait_cyc(c + 6); chk("rst_lvl_on",    int'(bif.btn_level), 15);
    wait_cyc(c + 7);
    bif.btn_raw = 4'b1111;
    for (int b = 0; b < 4; b++) push_ev(c + 13, b, 1'b1);
    wait_cyc(c + 13); chk("rst_lvl_off", int'(bif.btn_level), 0);
    wait_cyc(c + 20);

    // Clean press on mode, held 50 cycles: masked-off, single pulse only
    c = cyc;
    bif.btn_raw[BTN_MODE] = 1'b0;
    push_ev(c + 6, BTN_MODE, 1'b0);
    wait_cyc(c + 5); chk("mode_lvl_early", int'(bif.btn_level[BTN_MODE]), 0);
    wait_cyc(c + 6); chk("mode_lvl_on",    int'(bif.btn_level[BTN_MODE]), 1);
    chk("mode_press", int'(bif.btn_press[BTN_MODE]), 1);
    wait_cyc(c + 50); chk("mode_hold", int'(bif.btn_hold[BTN_MODE]), 0);
    c = cyc;
    bif.btn_raw[BTN_MODE] = 1'b1;
    push_ev(c + 6, BTN_MODE, 1'b1);
    wait_cyc(c + 12);

    // Bounce on sel: 3 low, 1 high, 3 low, then high
    c = cyc;
    bif.btn_raw[BTN_SEL] = 1'b0;
    wait_cyc(c + 3); bif.btn_raw[BTN_SEL] = 1'b1;
    wait_cyc(c + 4); bif.btn_raw[BTN_SEL] = 1'b0;
    wait_cyc(c + 6); chk("bounce_lvl_a", int'(bif.btn_level[BTN_SEL]), 0);
    wait_cyc(c + 7); bif.btn_raw[BTN_SEL] = 1'b1;
    wait_cyc(c + 10); chk("bounce_lvl_b", int'(bif.btn_level[BTN_SEL]), 0);
    wait_cyc(c + 16); chk("bounce_lvl_c", int'(bif.btn_level[BTN_SEL]), 0);

    // Auto-repeat on inc; release lands on a repeat terminal count
    c = cyc;
    p = c + 6;
    bif.btn_raw[BTN_INC] = 1'b0;
    push_ev(p,      BTN_INC, 1'b0);
    push_ev(p + 10, BTN_INC, 1'b0);
    push_ev(p + 13, BTN_INC, 1'b0);
    push_ev(p + 16, BTN_INC, 1'b0);
    push_ev(p + 19, BTN_INC, 1'b1);
    wait_cyc(p + 9);  chk("inc_hold_pre",  int'(bif.btn_hold[BTN_INC]), 0);
    wait_cyc(p + 10); chk("inc_hold_on",   int'(bif.btn_hold[BTN_INC]), 1);
    wait_cyc(p + 13); bif.btn_raw[BTN_INC] = 1'b1;
    wait_cyc(p + 18); chk("inc_hold_last", int'(bif.btn_hold[BTN_INC]), 1);
    wait_cyc(p + 19); chk("inc_hold_off",  int'(bif.btn_hold[BTN_INC]), 0);
    chk("inc_lvl_off", int'(bif.btn_level[BTN_INC]), 0);
    wait_cyc(p + 30);

    // Reset in the middle of an inc hold, button kept down through it
    c = cyc;
    p = c + 6;
    bif.btn_raw[BTN_INC] = 1'b0;
    push_ev(p,      BTN_INC, 1'b0);
    push_ev(p + 10, BTN_INC, 1'b0);
    wait_cyc(p + 11); rst = 1'b1;
    wait_cyc(p + 12);
    chk("mid_rst_level",   int'(bif.btn_level),   0);
    chk("mid_rst_press",   int'(bif.btn_press),   0);
    chk("mid_rst_release", int'(bif.btn_release), 0);
    chk("mid_rst_hold",    int'(bif.btn_hold),    0);
    wait_cyc(p + 14);
    q = cyc;
    rst = 1'b0;
    push_ev(q + 6, BTN_INC, 1'b0);
    wait_cyc(q + 7);
    bif.btn_raw[BTN_INC] = 1'b1;
    push_ev(q + 13, BTN_INC, 1'b1);
    wait_cyc(q + 20);

    // Simultaneous mode + stop_alarm presses
    c = cyc;
    bif.btn_raw[BTN_MODE] = 1'b0;
    bif.btn_raw[BTN_STOP] = 1'b0;
    push_ev(c + 6, BTN_MODE, 1'b0);
    push_ev(c + 6, BTN_STOP, 1'b0);
    wait_cyc(c + 8);
    bif.btn_raw[BTN_MODE] = 1'b1;
    bif.btn_raw[BTN_STOP] = 1'b1;
    push_ev(c + 14, BTN_MODE, 1'b1);
    push_ev(c + 14, BTN_STOP, 1'b1);
    wait_cyc(c + 7); chk("dual_lvl", int'(bif.btn_level), 9);
    wait_cyc(c + 20);

    chk("missing_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
